// File: rtl/psg_write_fifo.sv
// Host-to-PSG write buffer: a small FIFO that replays bytes to the PSG data bus
// with a registered active-low strobe and an enforced idle gap between strobes.
module psg_write_fifo #(
  parameter int DEPTH     = 8,
  parameter int WE_CYCLES = 1,
  parameter int WRITE_GAP = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [7:0]                 psg_data,
  output logic                       psg_we_n,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (WE_CYCLES > WRITE_GAP) ? WE_CYCLES : WRITE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((WRITE_GAP > 0) ? (WRITE_GAP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               we_n_reg, we_n_next;
  logic [7:0]         data_reg, data_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [7:0]         mem [DEPTH];

  logic push;
  logic pop;

  assign in_ready = (level_reg != FULL_LVL) & ~flush;
  assign push     = in_valid & in_ready;
  // A flush suppresses starting a new strobe; one already running finishes.
  assign pop      = (state_reg == IDLE) & (level_reg != '0) & ~flush;

  assign psg_data = data_reg;
  assign psg_we_n = we_n_reg;
  assign level    = level_reg;
  assign busy     = (level_reg != '0) | (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_next = level_reg + LVL_W'(1);
        2'b01:   level_next = level_reg - LVL_W'(1);
        default: level_next = level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      we_n_reg   <= 1'b1;
      data_reg   <= 8'h00;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      we_n_reg   <= we_n_next;
      data_reg   <= data_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          state_next = STROBE;
        end
      end
      STROBE: begin
        if (cnt_reg == '0) begin
          state_next = (WRITE_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next  = cnt_reg;
    we_n_next = we_n_reg;
    data_next = data_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          data_next = mem[rd_ptr_reg];
          we_n_next = 1'b0;
          cnt_next  = WE_LOAD;
        end
      end
      STROBE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          we_n_next = 1'b1;
          cnt_next  = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        we_n_next = 1'b1;
        cnt_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_psg_write_fifo.sv
// Bench for psg_write_fifo: a scoreboard queue of accepted bytes is checked
// against every strobe, plus per-scenario timing and flag checks.
module tb_psg_write_fifo;

  localparam int WE_CYCLES = 1;
  localparam int WRITE_GAP = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] psg_data;
  logic       psg_we_n;
  logic       busy;
  logic [3:0] level;

  logic       rst2_n = 1'b1;
  logic [7:0] in2_data = 8'h00;
  logic       in2_valid = 1'b0;
  logic       in2_ready;
  logic       flush2 = 1'b0;
  logic [7:0] psg2_data;
  logic       psg2_we_n;
  logic       busy2;
  logic [2:0] level2;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int max_level = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  psg_write_fifo #(.DEPTH(8), .WE_CYCLES(WE_CYCLES), .WRITE_GAP(WRITE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .psg_data(psg_data),
    .psg_we_n(psg_we_n), .busy(busy), .level(level)
  );

  psg_write_fifo #(.DEPTH(4), .WE_CYCLES(4), .WRITE_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_data(in2_data), .in_valid(in2_valid),
    .in_ready(in2_ready), .flush(flush2), .psg_data(psg2_data),
    .psg_we_n(psg2_we_n), .busy(busy2), .level(level2)
  );

  // Strobe monitor for the main instance: order, strobe width and gap.
  logic       prev_we = 1'b1;
  int         low_cnt = 0;
  int         high_cnt = 0;
  bit         have_prev = 1'b0;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we   = 1'b1;
      low_cnt   = 0;
      high_cnt  = 0;
      have_prev = 1'b0;
    end else begin
      if (psg_we_n === 1'b0) begin
        if (prev_we === 1'b1) begin
          strobes++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected got data %h, required no strobe", psg_data);
          end else begin
            exp_byte = exp_q.pop_front();
            if (psg_data !== exp_byte) begin
              errors++;
              $display("FAIL strobe_data got %h required %h", psg_data, exp_byte);
            end
          end
          if (have_prev) begin
            checks++;
            if (high_cnt < WRITE_GAP + 1) begin
              errors++;
              $display("FAIL strobe_gap got %0d high cycles required >= %0d", high_cnt, WRITE_GAP + 1);
            end
          end
          low_cnt = 0;
        end
        low_cnt++;
      end else begin
        if (prev_we === 1'b0) begin
          checks++;
          if (low_cnt != WE_CYCLES) begin
            errors++;
            $display("FAIL strobe_width got %0d low cycles required %0d", low_cnt, WE_CYCLES);
          end
          have_prev = 1'b1;
          high_cnt  = 0;
        end
        high_cnt++;
      end
      prev_we = psg_we_n;
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  // Call right after a negedge; returns on the negedge following acceptance.
  task automatic push_byte(input logic [7:0] d, input int max_wait, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (in_ready === 1'b1) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_wait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    rst2_n = 1'b0;
    #2;
    checks++;
    if (psg_we_n !== 1'b1 || psg_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got we_n=%b data=%h required we_n=1 data=00", psg_we_n, psg_data);
    end
    checks++;
    if (busy !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b level=%0d required busy=0 level=0", busy, level);
    end
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || in2_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b/%b required 1/1", in_ready, in2_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    bit bad;
    @(negedge clk);
    push_byte(8'h8F, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept got timeout required accept"); end
    checks++;
    if (psg_we_n !== 1'b1 || level !== 4'd1) begin
      errors++;
      $display("FAIL single_latency got we_n=%b level=%0d required we_n=1 level=1", psg_we_n, level);
    end
    @(negedge clk);
    checks++;
    if (psg_we_n !== 1'b0 || psg_data !== 8'h8F) begin
      errors++;
      $display("FAIL single_strobe got we_n=%b data=%h required we_n=0 data=8f", psg_we_n, psg_data);
    end
    @(negedge clk);
    checks++;
    if (psg_we_n !== 1'b1 || psg_data !== 8'h8F || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_after got we_n=%b data=%h busy=%b required 1 8f 1", psg_we_n, psg_data, busy);
    end
    bad = 1'b0;
    repeat (WRITE_GAP - 1) begin
      @(negedge clk);
      if (busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL single_busy_gap got busy=0 early required busy=1 through gap"); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end got %b required 0", busy);
    end
    $display("test_single byte=8f strobes=%0d", strobes);
  endtask

  task automatic test_burst();
    bit ok;
    bit all_ok;
    int s0;
    logic [7:0] bytes [4];
    bytes[0] = 8'h80; bytes[1] = 8'h3F; bytes[2] = 8'h9A; bytes[3] = 8'hE4;
    s0 = strobes;
    max_level = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_byte(bytes[i], 5, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (!all_ok) begin errors++; $display("FAIL burst_accept got timeout required back-to-back accept"); end
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_drain got timeout required idle"); end
    checks++;
    if (strobes - s0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_count got %0d strobes, %0d pending required 4, 0", strobes - s0, exp_q.size());
    end
    checks++;
    if (max_level < 3 || max_level > 4 || level !== 4'd0) begin
      errors++;
      $display("FAIL burst_level got peak %0d final %0d required peak 3..4 final 0", max_level, level);
    end
    $display("test_burst strobes=%0d peak_level=%0d", strobes - s0, max_level);
  endtask

  task automatic test_full();
    bit ok;
    bit all_ok;
    int s0;
    s0 = strobes;
    max_level = 0;
    push_byte(8'hA0, 5, ok);
    repeat (2) @(negedge clk);
    all_ok = ok;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'hB0 + 8'(i), 2, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (!all_ok) begin errors++; $display("FAIL full_fill got timeout required accept"); end
    #1;
    checks++;
    if (level !== 4'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got level=%0d ready=%b required level=8 ready=0", level, in_ready);
    end
    all_ok = 1'b1;
    for (int i = 8; i < 10; i++) begin
      push_byte(8'hB0 + 8'(i), 200, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (!all_ok) begin errors++; $display("FAIL full_late_accept got timeout required accept"); end
    wait_idle(2000, ok);
    checks++;
    if (!ok || strobes - s0 != 11 || exp_q.size() != 0 || max_level != 8) begin
      errors++;
      $display("FAIL full_drain got strobes=%0d pending=%0d peak=%0d required 11 0 8", strobes - s0, exp_q.size(), max_level);
    end
    $display("test_full strobes=%0d peak_level=%0d", strobes - s0, max_level);
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok;
    int s0;
    s0 = strobes;
    max_level = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h40 + 8'(i), 200, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (!all_ok) begin errors++; $display("FAIL wrap_accept got timeout required accept"); end
    wait_idle(2000, ok);
    checks++;
    if (!ok || strobes - s0 != 20 || exp_q.size() != 0 || max_level != 8) begin
      errors++;
      $display("FAIL wrap_drain got strobes=%0d pending=%0d peak=%0d required 20 0 8", strobes - s0, exp_q.size(), max_level);
    end
    $display("test_wrap strobes=%0d peak_level=%0d", strobes - s0, max_level);
  endtask

  task automatic test_flush();
    bit ok;
    bit all_ok;
    bit seen;
    int s0;
    s0 = strobes;
    push_byte(8'hC0, 5, ok);
    repeat (2) @(negedge clk);
    all_ok = ok;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'hD1 + 8'(i), 2, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (!all_ok) begin errors++; $display("FAIL flush_queue got timeout required accept"); end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (psg_we_n === 1'b0) begin seen = 1'b1; break; end
    end
    #1;
    checks++;
    if (!seen || exp_q.size() != 4 || psg_data !== 8'hD1) begin
      errors++;
      $display("FAIL flush_first_strobe got seen=%b pending=%0d data=%h required 1 4 d1", seen, exp_q.size(), psg_data);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b required 0", in_ready); end
    exp_q.delete();
    @(negedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (level !== 4'd0 || psg_we_n !== 1'b1 || psg_data !== 8'hD1) begin
      errors++;
      $display("FAIL flush_clear got level=%0d we_n=%b data=%h required 0 1 d1", level, psg_we_n, psg_data);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (strobes - s0 != 2 || busy !== 1'b0 || psg_data !== 8'hD1) begin
      errors++;
      $display("FAIL flush_quiet got strobes=%0d busy=%b data=%h required 2 0 d1", strobes - s0, busy, psg_data);
    end
    $display("test_flush strobes=%0d", strobes - s0);
  endtask

  task automatic test_async_reset();
    int low;
    @(negedge clk);
    in2_valid = 1'b1;
    in2_data = 8'h5A;
    #1;
    checks++;
    if (in2_ready !== 1'b1) begin errors++; $display("FAIL rst_push1 got ready=%b required 1", in2_ready); end
    @(negedge clk);
    in2_valid = 1'b0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (psg2_we_n === 1'b0) low++;
    end
    checks++;
    if (low != 4 || psg2_data !== 8'h5A || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_width got low=%0d data=%h busy=%b required 4 5a 0", low, psg2_data, busy2);
    end
    in2_valid = 1'b1;
    in2_data = 8'h6B;
    @(negedge clk);
    in2_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (psg2_we_n !== 1'b0 || psg2_data !== 8'h6B) begin
      errors++;
      $display("FAIL rst_mid_strobe got we_n=%b data=%h required 0 6b", psg2_we_n, psg2_data);
    end
    #1 rst2_n = 1'b0;
    #1;
    checks++;
    if (psg2_we_n !== 1'b1 || psg2_data !== 8'h00 || level2 !== 3'd0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got we_n=%b data=%h level=%0d busy=%b required 1 00 0 0", psg2_we_n, psg2_data, level2, busy2);
    end
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (level2 !== 3'd0 || busy2 !== 1'b0 || psg2_we_n !== 1'b1 || in2_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release got level=%0d busy=%b we_n=%b ready=%b required 0 0 1 1", level2, busy2, psg2_we_n, in2_ready);
    end
    $display("test_async_reset low_cycles=%0d", low);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
